// File: rtl/led_pattern_decoder.sv
// Receive-side checker for the LED strip: works out which of the four strip patterns is playing and reports it with a lock flag and an error pulse.
// Optional feature: define STALL_TIMEOUT_EN to drop lock after TIMEOUT cycles of a frozen strip.
module led_pattern_decoder #(
    parameter int WIDTH   = 16,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] LEDs_strip,
    output logic [1:0]       MOD_det,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);

    if (WIDTH < 4 || LOCK_N < 1 || LOCK_N > 15 || TIMEOUT < 1) begin : g_param_check
        $error("led_pattern_decoder: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       mod_q, mod_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             evt;
    logic [3:0]       hit;
    logic [3:0]       cnt_inc;

`ifdef STALL_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
    logic [SW-1:0] stall_q, stall_d;
`endif

    // Expected next strip value if the previous sample belonged to mode m.
    function automatic logic [WIDTH-1:0] next_pat(input logic [1:0] m, input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] r;
        case (m)
            2'd0:    r = {p[WIDTH-2:0], p[WIDTH-1]};
            2'd1:    r = {p[0], p[WIDTH-1:1]};
            2'd2:    r = (&p) ? '0 : {p[WIDTH-2:0], 1'b1};
            default: r = ~p;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] lowest_hit(input logic [3:0] h);
        logic [1:0] r;
        if (h[0])      r = 2'd0;
        else if (h[1]) r = 2'd1;
        else if (h[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    always_comb begin
        s_d = LEDs_strip;
        p_d = s_q;
        evt = (s_q != p_q);
        hit = '0;
        for (int m = 0; m < 4; m++) begin
            hit[m] = evt && (s_q == next_pat(2'(m), p_q));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        mod_d   = mod_q;
        err_d   = 1'b0;
        cnt_inc = cnt_q + 4'd1;
`ifdef STALL_TIMEOUT_EN
        stall_d = '0;
`endif
        if (evt) begin
            case (state_q)
                SEARCH: begin
                    if (|hit) begin
                        cand_d  = lowest_hit(hit);
                        cnt_d   = 4'd1;
                        state_d = (LOCK_N == 1) ? LOCKED : TRACK;
                    end
                end
                TRACK: begin
                    if (hit[cand_q]) begin
                        // cnt saturates at LOCK_N once the lock is reached
                        if (cnt_inc >= LOCK_N_C) begin
                            cnt_d   = LOCK_N_C;
                            state_d = LOCKED;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (|hit) begin
                        cand_d  = lowest_hit(hit);
                        cnt_d   = 4'd1;
                        state_d = (LOCK_N == 1) ? LOCKED : TRACK;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!hit[cand_q]) begin
                        err_d = 1'b1;
                        if (|hit) begin
                            cand_d  = lowest_hit(hit);
                            cnt_d   = 4'd1;
                            state_d = TRACK;
                        end else begin
                            cnt_d   = 4'd0;
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = SEARCH;
                end
            endcase
        end
`ifdef STALL_TIMEOUT_EN
        else if (state_q == LOCKED) begin
            if (stall_q == STALL_LAST) begin
                err_d   = 1'b1;
                cnt_d   = 4'd0;
                state_d = SEARCH;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
`endif
        if (state_d == LOCKED && state_q != LOCKED) begin
            mod_d = cand_d;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= SEARCH;
            s_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            cand_q   <= '0;
            mod_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef STALL_TIMEOUT_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            mod_q    <= mod_d;
            locked_q <= locked_d;
            err_q    <= err_d;
`ifdef STALL_TIMEOUT_EN
            stall_q  <= stall_d;
`endif
        end
    end

    assign MOD_det = mod_q;
    assign locked  = locked_q;
    assign err     = err_q;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Self-checking bench for led_pattern_decoder: directed pattern scenarios plus random strip traffic against a behavioural model.
module tb_led_pattern_decoder;
    localparam int W       = 16;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 1024;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic [W-1:0] LEDs_strip = '0;
    logic [1:0]   MOD_det;
    logic         locked;
    logic         err;

    int checks = 0;
    int errors = 0;

    led_pattern_decoder #(.WIDTH(W), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .LEDs_strip(LEDs_strip),
        .MOD_det(MOD_det), .locked(locked), .err(err)
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural model: pipeline samples plus lock bookkeeping (cand = -1 while searching).
    int unsigned m_s, m_p;
    bit          m_locked, m_err;
    int          m_cand, m_run, m_mode, m_stall;
    logic [3:0]  exp_q[$];

    function automatic int unsigned succ(int m, int unsigned v);
        int unsigned full = (1 << W) - 1;
        case (m)
            0:       return (v * 2) % (1 << W) + v / (1 << (W - 1));
            1:       return v / 2 + (v % 2) * (1 << (W - 1));
            2:       return (v == full) ? 0 : (v * 2 + 1) % (1 << W);
            default: return full - v;
        endcase
    endfunction

    task automatic model_reset();
        m_s = 0; m_p = 0; m_locked = 0; m_err = 0;
        m_cand = -1; m_run = 0; m_mode = 0; m_stall = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit h[4];
        int first = -1;
        m_err = 0;
        if (m_s != m_p) begin
            for (int m = 0; m < 4; m++) begin
                h[m] = (m_s == succ(m, m_p));
                if (h[m] && first < 0) first = m;
            end
            m_stall = 0;
            if (m_locked) begin
                if (!h[m_cand]) begin
                    m_err = 1; m_locked = 0;
                    m_cand = first; m_run = (first >= 0) ? 1 : 0;
                end
            end else if (m_cand >= 0 && h[m_cand]) begin
                m_run++;
                if (m_run >= LOCK_N) begin m_locked = 1; m_mode = m_cand; end
            end else begin
                m_cand = first; m_run = (first >= 0) ? 1 : 0;
            end
        end else begin
`ifdef STALL_TIMEOUT_EN
            if (m_locked) begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_err = 1; m_locked = 0; m_cand = -1; m_run = 0; m_stall = 0;
                end
            end else begin
                m_stall = 0;
            end
`endif
        end
        m_p = m_s;
        m_s = int'(LEDs_strip);
        exp_q.push_back({m_err, m_locked, 2'(m_mode)});
    endtask

    task automatic step(input logic [W-1:0] v);
        @(negedge CLOCK);
        LEDs_strip = v;
        @(posedge CLOCK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        LEDs_strip = '0;
        repeat (2) @(posedge CLOCK);
        model_reset();
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        do_reset();
        #1;
        checks++;
        if ({err, locked, MOD_det} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_values got err=%0b locked=%0b mod=%0d want 0 0 0", err, locked, MOD_det);
        end
        step('0);
        e = exp_q.pop_front();
        checks++;
        if ({err, locked, MOD_det} !== e) begin
            errors++;
            $display("FAIL reset_idle got %b want %b", {err, locked, MOD_det}, e);
        end
    endtask

    task automatic test_shift_left();
        logic [3:0]   e;
        logic [W-1:0] v = 16'h0001;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(v);
            e = exp_q.pop_front();
            checks++;
            if ({err, locked, MOD_det} !== e) begin
                errors++;
                $display("FAIL shift_left step %0d got %b want %b", i, {err, locked, MOD_det}, e);
            end
            if (i == 5) begin
                checks++;
                if (locked !== 1'b1 || MOD_det !== 2'd0) begin
                    errors++;
                    $display("FAIL shift_left_lock got locked=%0b mod=%0d want 1 0", locked, MOD_det);
                end
            end
            v = W'(succ(0, int'(v)));
        end
        // The run above passed through 0x8000 -> 0x0001.
        checks++;
        if (locked !== 1'b1 || err !== 1'b0 || MOD_det !== 2'd0) begin
            errors++;
            $display("FAIL shift_left_wrap got locked=%0b err=%0b mod=%0d want 1 0 0", locked, err, MOD_det);
        end
    endtask

    task automatic test_blink_overlap();
        logic [3:0] e;
        logic [W-1:0] seq [6] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        int err_seen = 0;
        do_reset();
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front();
            if (err === 1'b1) err_seen++;
            checks++;
            if ({err, locked, MOD_det} !== e) begin
                errors++;
                $display("FAIL blink step %0d got %b want %b", i, {err, locked, MOD_det}, e);
            end
        end
        checks++;
        if (locked !== 1'b1 || MOD_det !== 2'd3 || err_seen != 0) begin
            errors++;
            $display("FAIL blink_lock got locked=%0b mod=%0d errs=%0d want 1 3 0", locked, MOD_det, err_seen);
        end
    endtask

    task automatic test_fill_loss();
        logic [3:0] e;
        logic [W-1:0] seq [8] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F,
                                  16'h1234, 16'h1234, 16'h1234};
        do_reset();
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front();
            checks++;
            if ({err, locked, MOD_det} !== e) begin
                errors++;
                $display("FAIL fill step %0d got %b want %b", i, {err, locked, MOD_det}, e);
            end
            if (i == 4) begin
                checks++;
                if (locked !== 1'b1 || MOD_det !== 2'd2) begin
                    errors++;
                    $display("FAIL fill_lock got locked=%0b mod=%0d want 1 2", locked, MOD_det);
                end
            end
            if (i == 6) begin
                checks++;
                if (err !== 1'b1 || locked !== 1'b0 || MOD_det !== 2'd2) begin
                    errors++;
                    $display("FAIL fill_err got err=%0b locked=%0b mod=%0d want 1 0 2", err, locked, MOD_det);
                end
            end
            if (i == 7) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_err_width got err=%0b want 0", err);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [3:0] e;
        logic [W-1:0] seq [12] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0010,
                                   16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h8000, 16'h8000};
        int err_seen = 0;
        do_reset();
        foreach (seq[i]) begin
            step(seq[i]);
            e = exp_q.pop_front();
            if (i >= 6 && err === 1'b1) err_seen++;
            checks++;
            if ({err, locked, MOD_det} !== e) begin
                errors++;
                $display("FAIL switch step %0d got %b want %b", i, {err, locked, MOD_det}, e);
            end
        end
        checks++;
        if (locked !== 1'b1 || MOD_det !== 2'd1 || err_seen != 1) begin
            errors++;
            $display("FAIL switch_relock got locked=%0b mod=%0d errs=%0d want 1 1 1", locked, MOD_det, err_seen);
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [W-1:0] v = 16'h0001;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(v);
            void'(exp_q.pop_front());
            v = W'(succ(0, int'(v)));
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL midlock_pre got locked=%0b want 1", locked);
        end
        #1 RESET = 1'b1;
        #1;
        checks++;
        if ({err, locked, MOD_det} !== 4'b0000) begin
            errors++;
            $display("FAIL midlock_async got %b want 0000", {err, locked, MOD_det});
        end
        @(posedge CLOCK); #1;
        checks++;
        if (err !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midlock_held got err=%0b locked=%0b want 0 0", err, locked);
        end
        do_reset();
    endtask

    task automatic test_mode_sequence();
        logic [3:0]   e;
        int           modes [4] = '{3, 0, 1, 2};
        logic [W-1:0] starts [4] = '{16'h0000, 16'h0001, 16'h8000, 16'h0000};
        logic [W-1:0] v;
        do_reset();
        foreach (modes[k]) begin
            v = starts[k];
            for (int i = 0; i < 25; i++) begin
                step(v);
                e = exp_q.pop_front();
                checks++;
                if ({err, locked, MOD_det} !== e) begin
                    errors++;
                    $display("FAIL modeseq m%0d step %0d got %b want %b", modes[k], i, {err, locked, MOD_det}, e);
                end
                v = W'(succ(modes[k], int'(v)));
            end
            checks++;
            if (locked !== 1'b1 || MOD_det !== 2'(modes[k])) begin
                errors++;
                $display("FAIL modeseq_follow got locked=%0b mod=%0d want 1 %0d", locked, MOD_det, modes[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]   e;
        logic [W-1:0] v = 16'h0001;
        int           err_seen = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(v);
            void'(exp_q.pop_front());
            v = W'(succ(2, int'(v)));
        end
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            step(LEDs_strip);
            e = exp_q.pop_front();
            if (err === 1'b1) err_seen++;
            checks++;
            if ({err, locked, MOD_det} !== e) begin
                errors++;
                $display("FAIL stall step %0d got %b want %b", i, {err, locked, MOD_det}, e);
            end
        end
        checks++;
`ifdef STALL_TIMEOUT_EN
        if (err_seen != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL stall_timeout got errs=%0d locked=%0b want 1 0", err_seen, locked);
        end
`else
        if (err_seen != 0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got errs=%0d locked=%0b want 0 1", err_seen, locked);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0]   e;
        logic [W-1:0] v;
        int           mode = $urandom_range(0, 3);
        int           r;
        do_reset();
        v = '0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) mode = $urandom_range(0, 3);
            if (r < 78)      v = W'(succ(mode, int'(v)));
            else if (r < 88) v = v;
            else             v = W'($urandom);
            step(v);
            e = exp_q.pop_front();
            checks++;
            if ({err, locked, MOD_det} !== e) begin
                errors++;
                $display("FAIL random step %0d got %b want %b", i, {err, locked, MOD_det}, e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_shift_left();
        test_blink_overlap();
        test_fill_loss();
        test_mode_switch();
        test_reset_mid_lock();
        test_mode_sequence();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
